// File: rtl/key_lock_ctrl.sv
// Serially loaded key lock: XOR-keys a data word and evaluates key-programmed 2-input LUT cells.
// Optional even-parity check on the loaded key is enabled by defining KEY_LOCK_PARITY_EN.
module key_lock_ctrl #(
    parameter int DATA_W  = 32,
    parameter int LUT_CNT = 1
) (
    input  logic                CK,
    input  logic                RST_N,
    input  logic                key_in,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic                key_start,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [LUT_CNT-1:0]  lut_a,
    input  logic [LUT_CNT-1:0]  lut_b,
    input  logic                in_valid,
    output logic [DATA_W-1:0]   data_out,
    output logic [LUT_CNT-1:0]  lut_out,
    output logic                out_valid,
    output logic                unlocked,
    output logic                key_err
);

    // state  | meaning
    // IDLE   | no key load in progress, datapath locked
    // LOAD   | shifting serial key bits into the shadow register
    // COMMIT | shadow copied into the active key
    // ACTIVE | committed key drives the datapath

    localparam int KEY_W = DATA_W + 4*LUT_CNT;
`ifdef KEY_LOCK_PARITY_EN
    localparam int LOAD_BITS = KEY_W + 1;
`else
    localparam int LOAD_BITS = KEY_W;
`endif
    localparam int CNT_W = $clog2(LOAD_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LOAD_BITS - 1);
    localparam logic [CNT_W-1:0] KEY_CNT  = CNT_W'(KEY_W);

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT, ACTIVE} state_t;

    state_t             r_state;
    logic [KEY_W-1:0]   r_shadow;
    logic [KEY_W-1:0]   r_key;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_key_ready;
    logic               r_unlocked;
    logic [DATA_W-1:0]  r_data_out;
    logic [LUT_CNT-1:0] r_lut_out;
    logic               r_out_valid;

    logic               w_accept;
    logic               w_shift;
    logic               w_last;
    logic [DATA_W-1:0]  w_xor_key;
    logic [LUT_CNT-1:0] w_lut;

    assign w_accept = (r_state == LOAD) && key_valid && !key_start;
    // the parity bit (when present) arrives after the key and is never shifted in
    assign w_shift  = w_accept && (r_cnt != KEY_CNT);
    assign w_last   = w_accept && (r_cnt == LAST_CNT);

`ifdef KEY_LOCK_PARITY_EN
    logic r_key_err;
    logic r_was_unlocked;
    logic w_par_ok;
    assign w_par_ok = (key_in == ^r_shadow);
    assign key_err  = r_key_err;
`else
    assign key_err  = 1'b0;
`endif

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            r_state        <= IDLE;
            r_shadow       <= '0;
            r_key          <= '0;
            r_cnt          <= '0;
            r_key_ready    <= 1'b0;
            r_unlocked     <= 1'b0;
`ifdef KEY_LOCK_PARITY_EN
            r_key_err      <= 1'b0;
            r_was_unlocked <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (key_start) begin
                        r_state        <= LOAD;
                        r_key_ready    <= 1'b1;
                        r_cnt          <= '0;
                        r_shadow       <= '0;
`ifdef KEY_LOCK_PARITY_EN
                        r_key_err      <= 1'b0;
                        r_was_unlocked <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (key_start) begin
                        r_cnt     <= '0;
                        r_shadow  <= '0;
`ifdef KEY_LOCK_PARITY_EN
                        r_key_err <= 1'b0;
`endif
                    end else if (w_accept) begin
                        if (w_shift) r_shadow <= {key_in, r_shadow[KEY_W-1:1]};
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_key_ready <= 1'b0;
`ifdef KEY_LOCK_PARITY_EN
                            if (w_par_ok) begin
                                r_state <= COMMIT;
                            end else begin
                                r_key_err  <= 1'b1;
                                r_unlocked <= r_was_unlocked;
                                r_state    <= r_was_unlocked ? ACTIVE : IDLE;
                            end
`else
                            r_state <= COMMIT;
`endif
                        end
                    end
                end
                COMMIT: begin
                    r_key      <= r_shadow;
                    r_unlocked <= 1'b1;
                    r_state    <= ACTIVE;
                end
                ACTIVE: begin
                    if (key_start) begin
                        r_state        <= LOAD;
                        r_key_ready    <= 1'b1;
                        r_cnt          <= '0;
                        r_shadow       <= '0;
                        r_unlocked     <= 1'b0;
`ifdef KEY_LOCK_PARITY_EN
                        r_key_err      <= 1'b0;
                        r_was_unlocked <= 1'b1;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_xor_key = r_unlocked ? r_key[DATA_W-1:0] : '0;

    for (genvar g = 0; g < LUT_CNT; g++) begin : g_lut
        logic [3:0] w_tt;
        assign w_tt     = r_key[DATA_W + 4*g +: 4];
        assign w_lut[g] = r_unlocked & w_tt[{lut_b[g], lut_a[g]}];
    end

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            r_data_out  <= '0;
            r_lut_out   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_data_out <= data_in ^ w_xor_key;
                r_lut_out  <= w_lut;
            end
        end
    end

    assign key_ready = r_key_ready;
    assign unlocked  = r_unlocked;
    assign data_out  = r_data_out;
    assign lut_out   = r_lut_out;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_key_lock_ctrl.sv
// Randomized scoreboard bench for key_lock_ctrl; exercises parity checking when KEY_LOCK_PARITY_EN is defined.
module tb_key_lock_ctrl;
    localparam int DATA_W  = 32;
    localparam int LUT_CNT = 1;
    localparam int KEY_W   = DATA_W + 4*LUT_CNT;
`ifdef KEY_LOCK_PARITY_EN
    localparam int NB = KEY_W + 1;
`else
    localparam int NB = KEY_W;
`endif

    logic              CK = 1'b0;
    logic              RST_N = 1'b1;
    logic              key_in = 1'b0;
    logic              key_valid = 1'b0;
    logic              key_start = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              lut_a = 1'b0;
    logic              lut_b = 1'b0;
    logic              key_ready;
    logic [DATA_W-1:0] data_out;
    logic              lut_out;
    logic              out_valid;
    logic              unlocked;
    logic              key_err;

    key_lock_ctrl #(.DATA_W(DATA_W), .LUT_CNT(LUT_CNT)) dut (
        .CK(CK), .RST_N(RST_N), .key_in(key_in), .key_valid(key_valid),
        .key_ready(key_ready), .key_start(key_start), .data_in(data_in),
        .lut_a(lut_a), .lut_b(lut_b), .in_valid(in_valid), .data_out(data_out),
        .lut_out(lut_out), .out_valid(out_valid), .unlocked(unlocked), .key_err(key_err)
    );

    always #5 CK = ~CK;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              l;
    } exp_t;

    int               checks = 0;
    int               errors = 0;
    exp_t             q[$];
    logic [DATA_W-1:0] last_d = '0;
    logic              last_l = 1'b0;
    logic [KEY_W-1:0]  m_key = '0;
    bit                m_unlocked = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: XOR with the committed key, LUT output is the truth-table entry {b,a}; zero key while locked.
    function automatic exp_t model(input logic [DATA_W-1:0] d, input logic a, input logic b);
        exp_t       e;
        logic [3:0] tt;
        tt  = m_key[DATA_W +: 4];
        e.d = m_unlocked ? (d ^ m_key[DATA_W-1:0]) : d;
        e.l = m_unlocked ? tt[{b, a}] : 1'b0;
        return e;
    endfunction

    always @(posedge CK) begin
        exp_t e;
        #1;
        if (out_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid actual=1 expected=0 at %0t", $time);
            end else begin
                e = q.pop_front();
                chk("data_out", 64'(data_out), 64'(e.d));
                chk("lut_out", 64'(lut_out), 64'(e.l));
                last_d = e.d;
                last_l = e.l;
            end
        end else begin
            chk("hold_data_out", 64'(data_out), 64'(last_d));
            chk("hold_lut_out", 64'(lut_out), 64'(last_l));
        end
    end

    task automatic drive(input logic [DATA_W-1:0] d, input logic a, input logic b, input exp_t e);
        @(negedge CK);
        data_in  = d;
        lut_a    = a;
        lut_b    = b;
        in_valid = 1'b1;
        q.push_back(e);
    endtask

    task automatic idle_in();
        @(negedge CK);
        in_valid = 1'b0;
    endtask

    task automatic burst(input int n);
        logic [DATA_W-1:0] d;
        logic a, b;
        for (int i = 0; i < n; i++) begin
            d = $urandom();
            a = 1'($urandom_range(1, 0));
            b = 1'($urandom_range(1, 0));
            drive(d, a, b, model(d, a, b));
        end
        idle_in();
    endtask

    task automatic load_key(input logic [KEY_W-1:0] k, input bit toggle, input int abort_at,
                            input logic [KEY_W-1:0] junk, input bit bad_par);
        int  i, cyc;
        bit  ph, prior;
        prior = m_unlocked;
        @(negedge CK);
        key_start = 1'b1;
        key_valid = 1'b0;
        @(negedge CK);
        key_start  = 1'b0;
        m_unlocked = 1'b0;
        chk("key_ready_in_load", 64'(key_ready), 64'd1);
        chk("unlocked_in_load", 64'(unlocked), 64'd0);
        i = 0; cyc = 0; ph = 1'b0;
        while (i < NB && cyc < 500) begin
            if (abort_at > 0 && i == abort_at) begin
                key_start = 1'b1;
                key_valid = 1'b1;
                key_in    = 1'b1;
                @(negedge CK);
                key_start = 1'b0;
                abort_at  = 0;
                i = 0;
                cyc++;
                continue;
            end
            key_valid = toggle ? ph : 1'b1;
            if (i < KEY_W) key_in = (abort_at > 0) ? junk[i] : k[i];
            else           key_in = (^k) ^ bad_par;
            if (key_valid) chk("key_ready_bit", 64'(key_ready), 64'd1);
            @(negedge CK);
            if (key_valid) i++;
            cyc++;
            ph = ~ph;
        end
        key_valid = 1'b0;
        if (i < NB) begin
            checks++;
            errors++;
            $display("FAIL load_timeout actual=%0d expected=%0d bits", i, NB);
        end
        chk("key_ready_after_last", 64'(key_ready), 64'd0);
        if (bad_par) begin
            chk("key_err_bad_parity", 64'(key_err), 64'd1);
            chk("unlocked_restored", 64'(unlocked), 64'(prior));
            m_unlocked = prior;
        end else begin
            chk("unlocked_commit_cycle", 64'(unlocked), 64'd0);
            @(negedge CK);
            chk("unlocked_after_commit", 64'(unlocked), 64'd1);
            chk("key_err_good_load", 64'(key_err), 64'd0);
            m_key      = k;
            m_unlocked = 1'b1;
        end
    endtask

    function automatic logic [KEY_W-1:0] rand_key();
        return {4'($urandom_range(15, 0)), 32'($urandom())};
    endfunction

    initial begin
        exp_t e;
        logic [KEY_W-1:0] ka, kb;
        #2 RST_N = 1'b0;
        @(negedge CK);
        chk("rst_data_out", 64'(data_out), 64'd0);
        chk("rst_lut_out", 64'(lut_out), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_unlocked", 64'(unlocked), 64'd0);
        chk("rst_key_ready", 64'(key_ready), 64'd0);
        chk("rst_key_err", 64'(key_err), 64'd0);
        @(negedge CK);
        RST_N = 1'b1;

        // locked: pass-through
        e.d = 32'hA5A5A5A5; e.l = 1'b0;
        drive(32'hA5A5A5A5, 1'b0, 1'b0, e);
        drive(32'hA5A5A5A5, 1'b1, 1'b1, e);
        idle_in();
        chk("unlocked_locked", 64'(unlocked), 64'd0);
        burst(6);

        // directed key: XOR FFFF0000, LUT table 0110
        load_key({4'b0110, 32'hFFFF0000}, 1'b0, 0, '0, 1'b0);
        e.d = 32'hEDCB5678; e.l = 1'b1;
        drive(32'h12345678, 1'b1, 1'b0, e);
        e.l = 1'b0;
        drive(32'h12345678, 1'b1, 1'b1, e);
        idle_in();
        burst(8);

        // key_valid every other cycle
        load_key(rand_key(), 1'b1, 0, '0, 1'b0);
        burst(8);

        // restart after 20 bits; only the second key may become active
        ka = rand_key();
        kb = ~ka;
        load_key(kb, 1'b0, 20, ka, 1'b0);
        burst(8);

        for (int n = 0; n < 3; n++) begin
            load_key(rand_key(), 1'($urandom_range(1, 0)), 0, '0, 1'b0);
            burst(5);
        end

`ifdef KEY_LOCK_PARITY_EN
        // bad parity while active keeps the prior key
        load_key(rand_key(), 1'b0, 0, '0, 1'b1);
        chk("unlocked_after_bad_par", 64'(unlocked), 64'd1);
        burst(6);
`endif

        // data during a load from ACTIVE sees the zero key
        @(negedge CK);
        key_start = 1'b1;
        @(negedge CK);
        key_start  = 1'b0;
        m_unlocked = 1'b0;
        burst(4);
        key_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            key_in = 1'($urandom_range(1, 0));
            @(negedge CK);
        end
        key_valid = 1'b0;

        // reset mid-load
        #2 RST_N = 1'b0;
        last_d = '0;
        last_l = 1'b0;
        m_key  = '0;
        m_unlocked = 1'b0;
        #1;
        chk("midrst_data_out", 64'(data_out), 64'd0);
        chk("midrst_lut_out", 64'(lut_out), 64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_unlocked", 64'(unlocked), 64'd0);
        chk("midrst_key_ready", 64'(key_ready), 64'd0);
        chk("midrst_key_err", 64'(key_err), 64'd0);
        @(negedge CK);
        RST_N = 1'b1;
        @(negedge CK);
        chk("idle_after_rst", 64'(key_ready), 64'd0);
        burst(4);

`ifdef KEY_LOCK_PARITY_EN
        // bad parity from a locked state returns to locked idle
        load_key(rand_key(), 1'b0, 0, '0, 1'b1);
        chk("unlocked_bad_par_locked", 64'(unlocked), 64'd0);
        burst(3);
`endif
        load_key(rand_key(), 1'b0, 0, '0, 1'b0);
        burst(8);

        repeat (3) @(negedge CK);
        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
